// File: rtl/tuple_bit_serializer_if.sv
// Tuple input / bit-serial output bundle for tuple_bit_serializer.
// master = serializer side, slave = producer/sink environment side.
interface tuple_bit_serializer_if #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
);
  logic             I__0;
  logic             I__1;
  logic             I_valid;
  logic             I_ready;
  logic             O_data;
  logic             O_valid;
  logic             O_ready;
  logic             O_last;
  logic [CNT_W-1:0] count;

  modport master (
    input  I__0, I__1, I_valid, O_ready,
    output I_ready, O_data, O_valid, O_last, count
  );

  modport slave (
    output I__0, I__1, I_valid, O_ready,
    input  I_ready, O_data, O_valid, O_last, count
  );
endinterface

// File: rtl/tuple_bit_serializer.sv
// Buffers {I__1,I__0} tuples in a FIFO and streams them bit-serially, element 0 first.
// Define TUPLE_SERIALIZER_PARITY_EN to append a third (XOR parity) beat per tuple.
module tuple_bit_serializer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESETN,
  tuple_bit_serializer_if.master bus
);
  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
`ifdef TUPLE_SERIALIZER_PARITY_EN
  localparam int SR_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2, BEATP = 2'd3} state_t;
`else
  localparam int SR_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;
`endif

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [1:0]        mem_q [DEPTH];
  logic [1:0]        head;
  logic [SR_W-1:0]   load;
  logic              push, pop, beat_hs, o_data, o_last;

  // Space is judged from registered occupancy only; a same-cycle pop never frees a slot.
  assign push = bus.I_valid && (count_q != FULL);
  assign head = mem_q[rd_ptr_q];
`ifdef TUPLE_SERIALIZER_PARITY_EN
  assign load = {^head, head};
`else
  assign load = head;
`endif

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    rd_ptr_d = rd_ptr_q;
    pop      = 1'b0;
    o_data   = 1'b0;
    o_last   = 1'b0;
    beat_hs  = (state_q != IDLE) && bus.O_ready;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = BEAT0;
        end
      end
      BEAT0: begin
        o_data = sr_q[0];
        if (beat_hs) state_d = BEAT1;
      end
`ifdef TUPLE_SERIALIZER_PARITY_EN
      BEAT1: begin
        o_data = sr_q[1];
        if (beat_hs) state_d = BEATP;
      end
      BEATP: begin
        o_data = sr_q[2];
        o_last = 1'b1;
        if (beat_hs) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = BEAT0;
          end else begin
            state_d = IDLE;
          end
        end
      end
`else
      BEAT1: begin
        o_data = sr_q[1];
        o_last = 1'b1;
        // Reload on the final beat so consecutive tuples stream without a bubble.
        if (beat_hs) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = BEAT0;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (pop) begin
      sr_d     = load;
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sr_q     <= sr_d;
    end
  end

  // FIFO storage is pure data; occupancy/pointers decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {bus.I__1, bus.I__0};
  end

  assign bus.I_ready = (count_q != FULL);
  assign bus.O_valid = (state_q != IDLE);
  assign bus.O_data  = o_data;
  assign bus.O_last  = o_last;
  assign bus.count   = count_q;
endmodule

// File: doc/tuple_bit_serializer.md
# tuple_bit_serializer

Downstream consumer of the two-element bit tuple (`O__0`, `O__1`) produced by the tuple-output combinational stage and its `CLK`-only wrapper. Accepts each tuple over a valid/ready handshake, buffers it in a small FIFO, and emits it as a bit-serial stream, element 0 first, with a last-beat marker. Sits between the tuple producer and any single-bit serial sink.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `CNT_W`, default `$clog2(DEPTH+1)`: occupancy counter width; derived, not overridden.

- `CLK` in 1: single clock, rising edge.
- `ASYNCRESETN` in 1: reset, asynchronous assert, active-low.
- `I__0` in 1: tuple element 0.
- `I__1` in 1: tuple element 1.
- `I_valid` in 1: tuple on `I__0`/`I__1` is valid.
- `I_ready` out 1: FIFO can accept; equals `count != DEPTH`.
- `O_data` out 1: current serial beat.
- `O_valid` out 1: `O_data` is valid.
- `O_ready` in 1: sink accepts beat.
- `O_last` out 1: current beat is the final beat of its tuple.
- `count` out CNT_W: FIFO occupancy, excluding the tuple in the shift register.

## Operation
- Push: `I_valid && I_ready` writes {`I__1`,`I__0`} at `wr_ptr`; `wr_ptr` increments modulo DEPTH.
- `I_ready` depends only on registered `count`. A same-cycle pop does not open space when full.
- FSM states: `IDLE`, `BEAT0`, `BEAT1`, plus `BEATP` when parity is enabled.
- `IDLE`: when `count != 0`, pop the head into the shift register and go to `BEAT0`.
- `BEAT0`: `O_data` = element 0. On `O_valid && O_ready`, go to `BEAT1`.
- `BEAT1`: `O_data` = element 1. On handshake:
  - parity disabled: reload from FIFO and go to `BEAT0` if `count != 0`, else `IDLE`.
  - parity enabled: go to `BEATP`.
- `BEATP`: `O_data` = element 0 XOR element 1. On handshake, reload/`IDLE` exactly as `BEAT1` does without parity.
- `O_valid` = (state != `IDLE`). `O_last` = 1 only in the final beat state.
- No handshake: state and `O_data` hold.
- Push and pop in the same cycle: both occur, `count` unchanged. Push only: +1. Pop only: −1.
- Pointers wrap at DEPTH. No bypass: a tuple pushed this cycle cannot be popped in the same cycle.

## Timing
- Reset values (async, immediate): state `IDLE`, pointers 0, `count` 0, `O_valid` 0, `O_data` 0, `O_last` 0, `I_ready` 1.
- Latency, empty block: tuple accepted at edge k, popped at edge k+1, `O_valid` high from k+1 to k+2. That is 1 cycle of buffering, then the first beat.
- Back-to-back: last-beat handshake and reload happen on the same edge, so consecutive tuples have no idle cycle.
- Throughput: 1 tuple per 2 cycles (per 3 cycles with parity) with `O_ready` held high.
- Reset mid-operation: all buffered and in-flight tuples are discarded, including partially sent ones. After deassertion the block is empty and waits for new input.
- Full FIFO with `I_valid` high: `I_ready`=0 and input is ignored. Pushes resume the cycle after `count` drops.

## Configuration
- `TUPLE_SERIALIZER_PARITY_EN` defined:
  - `BEATP` state is present and each tuple is 3 beats; `O_last` is on the parity beat.
  - Shift register is 3 bits.
- Undefined:
  - `BEATP` logic is absent and each tuple is 2 beats; `O_last` is on `BEAT1`.

## Test plan
- Reset behaviour: assert `ASYNCRESETN`=0 mid-cycle → all outputs take reset values immediately. Release → `I_ready`=1 and `count`=0.
- Single tuple (1,0) with `O_ready`=1: accept at edge 0 → `O_valid` from edge 1. `O_data` sequence 1,0 with `O_last` 0,1, then `O_valid`=0.
- Backpressure and full FIFO, DEPTH=2: hold `O_ready`=0 and push 3 tuples (1,1),(0,1),(1,0).
  - First is loaded, next two fill the FIFO, `count`=2, `I_ready`=0, the 4th tuple is refused.
  - Release `O_ready` → bits 1,1,0,1,1,0 with no bubbles.
- Simultaneous push and pop with `count`=1: `count` stays 1 and the output order is preserved across pointer wrap.
- Parity build, tuple (1,1): beats 1,1,0 with `O_last` only on beat 3.
- Reset during `BEAT1` with 2 tuples buffered: after release `O_valid`=0, `count`=0, and no stale bits appear.
